// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data RAM between the CPU execute
// stage (port A) and the UART loader/debug engine (port B). Round-robin on
// contention, plus a bounded lock that B can hold for atomic sequences.
// Read data returns one cycle after the grant as a per-port valid strobe.
module mem_port_arbiter #(
   parameter int AW       = 6,
   parameter int DW       = 32,
   parameter int MAX_LOCK = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic          b_lock,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          ram_en,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t state, state_nxt;
   logic        last, last_nxt;      // 0 = A granted last, 1 = B
   logic [7:0]  lock_cnt, lock_cnt_nxt;
   logic        pend_a, pend_b;
   logic        at_limit;

   assign at_limit = (lock_cnt >= MAX_CNT);

   // State register: lock FSM, round-robin pointer and read-return pipeline
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= UNLOCKED;
         last     <= 1'b1;
         lock_cnt <= '0;
         pend_a   <= 1'b0;
         pend_b   <= 1'b0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         lock_cnt <= lock_cnt_nxt;
         pend_a   <= a_gnt && !a_we;
         pend_b   <= b_gnt && !b_we;
      end
   end

   // Output logic: zero-latency grant and RAM drive from the granted port
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (state == LOCKED && b_req && !at_limit)
         b_gnt = 1'b1;
      else if (state == LOCKED && at_limit && a_req)
         a_gnt = 1'b1;
      else if (a_req && !b_req)
         a_gnt = 1'b1;
      else if (b_req && !a_req)
         b_gnt = 1'b1;
      else if (a_req && b_req) begin
         if (last) a_gnt = 1'b1;
         else      b_gnt = 1'b1;
      end

      ram_en    = a_gnt | b_gnt;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (a_gnt) begin
         ram_we    = a_we;
         ram_addr  = a_addr;
         ram_wdata = a_wdata;
      end else if (b_gnt) begin
         ram_we    = b_we;
         ram_addr  = b_addr;
         ram_wdata = b_wdata;
      end
   end

   // Next-state logic: round-robin pointer and B lock ownership/count
   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      last_nxt     = last;

      if (a_gnt)      last_nxt = 1'b0;
      else if (b_gnt) last_nxt = 1'b1;

      case (state)
         UNLOCKED: begin
            if (b_gnt && b_lock) begin
               state_nxt    = LOCKED;
               lock_cnt_nxt = 8'd1;
            end
         end
         LOCKED: begin
            if (b_gnt && b_lock) begin
               if (lock_cnt != 8'hFF) lock_cnt_nxt = lock_cnt + 8'd1;
            end else if (b_gnt || !b_req || a_gnt) begin
               state_nxt    = UNLOCKED;
               lock_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = UNLOCKED;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   assign a_rvalid = pend_a;
   assign b_rvalid = pend_b;
   assign a_rdata  = ram_rdata;
   assign b_rdata  = ram_rdata;

endmodule
